ysyx_22040365_ctrl: RTL and testbench

//  Multi-cycle sequencer for the NPC core. Drives instruction fetch over a valid/ready request and

---
 rtl/ysyx_22040365_defines.sv | 25 ++
 rtl/ysyx_22040365_pc_reg.sv | 25 ++
 rtl/ysyx_22040365_ctrl.sv | 125 ++++++++++++
 tb/tb_ysyx_22040365_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040365_defines.sv
// Shared definitions for the NPC multi-cycle sequencer: state encoding, ebreak word, halt causes.
package ysyx_22040365_defines;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_WAIT   = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    localparam logic [31:0] EBREAK_INST   = 32'h0010_0073;

    localparam logic [1:0]  CAUSE_NONE    = 2'd0;
    localparam logic [1:0]  CAUSE_EBREAK  = 2'd1;
    localparam logic [1:0]  CAUSE_ILLEGAL = 2'd2;
    localparam logic [1:0]  CAUSE_TIMEOUT = 2'd3;

    // Retire counter sticks at all-ones instead of wrapping.
    function automatic logic [63:0] sat_inc(input logic [63:0] v);
        return (&v) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/ysyx_22040365_pc_reg.sv
// Program counter: loads RESET_PC on reset, advances by 4 (wrapping) when inc_en is set.
module ysyx_22040365_pc_reg #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_en,
    output logic [63:0] pc
);

    logic [63:0] pc_d, pc_q;

    always_comb begin
        pc_d = pc_q;
        if (inc_en) pc_d = pc_q + 64'd4;
    end

    always_ff @(posedge clk) begin
        if (rst) pc_q <= RESET_PC;
        else     pc_q <= pc_d;
    end

    assign pc = pc_q;

endmodule

// File: rtl/ysyx_22040365_ctrl.sv
// Multi-cycle sequencer: fetch handshake, instruction register, execute/writeback strobes,
// retire counter and sticky halt with cause.
module ysyx_22040365_ctrl
    import ysyx_22040365_defines::*;
#(
    parameter logic [63:0] RESET_PC = 64'h8000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ifu_req_valid,
    input  logic        ifu_req_ready,
    input  logic        ifu_rsp_valid,
    input  logic [31:0] ifu_rsp_inst,
    output logic [31:0] inst,
    input  logic        id_inst_type,
    input  logic [4:0]  id_rd,
    output logic [63:0] pc,
    output logic        rf_ren,
    output logic        exu_en,
    output logic        rf_wen,
    output logic [63:0] retired,
    output logic        halt,
    output logic [1:0]  halt_cause
);

    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT);

    state_e      state_d, state_q;
    logic [31:0] inst_d, inst_q;
    logic [7:0]  timer_d, timer_q;
    logic [63:0] retired_d, retired_q;
    logic        halt_d, halt_q;
    logic [1:0]  cause_d, cause_q;
    logic        pc_inc;

    ysyx_22040365_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
        .clk    (clk),
        .rst    (rst),
        .inc_en (pc_inc),
        .pc     (pc)
    );

    always_comb begin
        state_d   = state_q;
        inst_d    = inst_q;
        timer_d   = timer_q;
        retired_d = retired_q;
        halt_d    = halt_q;
        cause_d   = cause_q;
        pc_inc    = 1'b0;
        unique case (state_q)
            ST_FETCH: begin
                if (ifu_req_ready) begin
                    state_d = ST_WAIT;
                    timer_d = '0;
                end
            end
            ST_WAIT: begin
                // A response in the last allowed cycle still wins over the timeout.
                if (ifu_rsp_valid) begin
                    inst_d  = ifu_rsp_inst;
                    state_d = ST_DECODE;
                end else begin
                    timer_d = timer_q + 8'd1;
                    if (timer_d == TIMEOUT_LIM) begin
                        state_d = ST_HALT;
                        halt_d  = 1'b1;
                        cause_d = CAUSE_TIMEOUT;
                    end
                end
            end
            ST_DECODE: begin
                if (inst_q == EBREAK_INST) begin
                    state_d   = ST_HALT;
                    halt_d    = 1'b1;
                    cause_d   = CAUSE_EBREAK;
                    retired_d = sat_inc(retired_q);
                end else if (id_inst_type) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_HALT;
                    halt_d  = 1'b1;
                    cause_d = CAUSE_ILLEGAL;
                end
            end
            ST_EXEC: state_d = ST_WB;
            ST_WB: begin
                pc_inc    = 1'b1;
                retired_d = sat_inc(retired_q);
                state_d   = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            inst_q    <= '0;
            timer_q   <= '0;
            retired_q <= '0;
            halt_q    <= 1'b0;
            cause_q   <= CAUSE_NONE;
        end else begin
            state_q   <= state_d;
            inst_q    <= inst_d;
            timer_q   <= timer_d;
            retired_q <= retired_d;
            halt_q    <= halt_d;
            cause_q   <= cause_d;
        end
    end

    assign ifu_req_valid = (state_q == ST_FETCH);
    assign rf_ren        = (state_q == ST_EXEC);
    assign exu_en        = (state_q == ST_EXEC);
    assign rf_wen        = (state_q == ST_WB) && (id_rd != 5'd0);
    assign inst          = inst_q;
    assign retired       = retired_q;
    assign halt          = halt_q;
    assign halt_cause    = cause_q;

endmodule

// File: tb/tb_ysyx_22040365_ctrl.sv
// Bench for ysyx_22040365_ctrl: random-latency memory, instruction-level reference model,
// per-cycle output comparison plus directed scenarios with hand-computed expectations.
module tb_ysyx_22040365_ctrl;

    localparam logic [63:0] RESET_PC = 64'h8000_0000;
    localparam int          TIMEOUT  = 255;
    localparam logic [31:0] EBREAK_W = 32'h0010_0073;
    localparam logic [31:0] ILLEGAL  = 32'h0000_0033;

    logic        clk, rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
    logic [31:0] ifu_rsp_inst, inst;
    logic        id_inst_type;
    logic [4:0]  id_rd;
    logic [63:0] pc, retired;
    logic        rf_ren, exu_en, rf_wen, halt;
    logic [1:0]  halt_cause;

    int n_checks = 0;
    int n_errs   = 0;

    ysyx_22040365_ctrl #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_inst(ifu_rsp_inst),
        .inst(inst), .id_inst_type(id_inst_type), .id_rd(id_rd), .pc(pc),
        .rf_ren(rf_ren), .exu_en(exu_en), .rf_wen(rf_wen),
        .retired(retired), .halt(halt), .halt_cause(halt_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in decoder: addi is opcode 0010011 with funct3 000.
    assign id_inst_type = (inst[6:0] == 7'b0010011) && (inst[14:12] == 3'b000);
    assign id_rd        = inst[11:7];

    function automatic bit is_addi(input logic [31:0] w);
        return (w[6:0] == 7'b0010011) && (w[14:12] == 3'b000);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // ---------------- instruction memory ----------------
    logic [31:0] prog [0:63];
    int  fix_rdy, fix_dly, cur_rdy, rv_cnt, dly_left;
    bit  noise, pend;
    logic [31:0] rsp_word, rnd;
    logic [63:0] off;

    initial begin
        ifu_req_ready = 0; ifu_rsp_valid = 0; ifu_rsp_inst = 0;
        pend = 0; rv_cnt = 0; cur_rdy = 0; dly_left = 0;
        forever begin
            @(negedge clk); #1;
            ifu_rsp_valid = 0;
            if (rst) begin
                pend = 0; rv_cnt = 0; ifu_req_ready = 0;
                continue;
            end
            if (pend) begin
                if (dly_left == 0) begin
                    ifu_rsp_valid = 1; ifu_rsp_inst = rsp_word; pend = 0;
                end else dly_left--;
            end
            if (ifu_req_valid) begin
                if (rv_cnt == 0) cur_rdy = (fix_rdy < 0) ? int'($urandom_range(0, 3)) : fix_rdy;
                ifu_req_ready = (rv_cnt >= cur_rdy);
                rv_cnt++;
                if (ifu_req_ready) begin
                    off      = pc - RESET_PC;
                    rsp_word = prog[off[7:2]];
                    dly_left = (fix_dly < 0) ? int'($urandom_range(0, 5)) : fix_dly;
                    pend     = 1;
                    rv_cnt   = 0;
                end
            end else begin
                rv_cnt = 0;
                ifu_req_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            // Stray responses while nothing is outstanding must be ignored.
            if (noise && !ifu_rsp_valid && !pend && $urandom_range(0, 5) == 0) begin
                ifu_rsp_valid = 1; ifu_rsp_inst = $urandom;
            end
        end
    end

    // ---------------- reference model (instruction-level program) ----------------
    logic [63:0] m_pc, m_ret;
    logic [31:0] m_inst;
    logic        m_halt;
    logic [1:0]  m_cause;
    logic        e_req, e_ren, e_exu, e_wen;
    bit          m_valid = 0;
    logic        s_rdy, s_rv;
    logic [31:0] s_ri;

    task automatic m_step(output bit ab);
        @(posedge clk);
        s_rdy = ifu_req_ready; s_rv = ifu_rsp_valid; s_ri = ifu_rsp_inst; ab = rst;
    endtask

    task automatic m_en(input bit r, input bit rn, input bit x, input bit w);
        e_req = r; e_ren = rn; e_exu = x; e_wen = w;
    endtask

    task automatic m_park(input logic [1:0] c);
        bit ab;
        m_halt = 1; m_cause = c; m_en(0, 0, 0, 0);
        forever begin
            m_step(ab);
            if (ab) return;
        end
    endtask

    task automatic m_run();
        bit ab, got;
        int waited;
        forever begin
            m_en(1, 0, 0, 0);
            do begin m_step(ab); if (ab) return; end while (!s_rdy);
            m_en(0, 0, 0, 0);
            waited = 0; got = 0;
            while (!got && waited < TIMEOUT) begin
                m_step(ab);
                if (ab) return;
                if (s_rv) begin m_inst = s_ri; got = 1; end
                else waited++;
            end
            if (!got) begin m_park(2'd3); return; end
            m_step(ab);
            if (ab) return;
            if (m_inst == EBREAK_W) begin
                if (m_ret != '1) m_ret = m_ret + 1;
                m_park(2'd1); return;
            end
            if (!is_addi(m_inst)) begin m_park(2'd2); return; end
            m_en(0, 1, 1, 0);
            m_step(ab);
            if (ab) return;
            m_en(0, 0, 0, m_inst[11:7] != 5'd0);
            m_step(ab);
            if (ab) return;
            m_pc = m_pc + 64'd4;
            if (m_ret != '1) m_ret = m_ret + 1;
        end
    endtask

    initial begin
        do @(posedge clk); while (!rst);
        forever begin
            m_pc = RESET_PC; m_inst = 0; m_ret = 0; m_halt = 0; m_cause = 0;
            m_en(1, 0, 0, 0);
            m_valid = 1;
            m_run();
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("req_valid", ifu_req_valid, e_req);
            chk("rf_ren", rf_ren, e_ren);
            chk("exu_en", exu_en, e_exu);
            chk("rf_wen", rf_wen, e_wen);
            chk("pc", pc, m_pc);
            chk("inst", inst, m_inst);
            chk("retired", retired, m_ret);
            chk("halt", halt, m_halt);
            chk("halt_cause", halt_cause, m_cause);
        end
    end

    // ---------------- directed + random stimulus ----------------
    int o_halt, o_wen, o_ren, o_exu, o_req, o_wen1, o_inst1;

    task automatic set_prog(input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < 64; i++) prog[i] = ILLEGAL;
        prog[0] = a; prog[1] = b;
    endtask

    task automatic apply_reset();
        @(negedge clk); rst = 1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", ifu_req_valid, 1);
        chk("rst_pc", pc, RESET_PC);
        chk("rst_inst", inst, 0);
        chk("rst_retired", retired, 0);
        chk("rst_halt", {halt, halt_cause}, 0);
        chk("rst_enables", {rf_ren, exu_en, rf_wen}, 0);
        @(posedge clk); #1 rst = 0;
    endtask

    task automatic run_obs(input int bound);
        o_halt = 0; o_wen = 0; o_ren = 0; o_exu = 0; o_req = 0; o_wen1 = 0; o_inst1 = 0;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk);
            if (rf_wen) begin o_wen++; if (o_wen1 == 0) o_wen1 = i; end
            if (rf_ren) o_ren++;
            if (exu_en) o_exu++;
            if (ifu_req_valid) o_req++;
            if (o_inst1 == 0 && inst != 0) o_inst1 = i;
            if (halt) begin o_halt = i; break; end
        end
        chk("halt_reached", halt, 1);
    endtask

    initial begin
        rst = 1; fix_rdy = 0; fix_dly = 0; noise = 0;
        for (int i = 0; i < 64; i++) prog[i] = ILLEGAL;

        // addi x1,x0,5 ; ebreak with zero-wait memory
        set_prog(32'h0050_0093, EBREAK_W);
        apply_reset(); run_obs(50);
        chk("t1_wen_cycle", o_wen1, 5);
        chk("t1_wen_count", o_wen, 1);
        chk("t1_halt_cycle", o_halt, 9);
        chk("t1_cause", halt_cause, 1);
        chk("t1_retired", retired, 2);
        chk("t1_pc", pc, RESET_PC + 4);
        chk("t1_model_ret", m_ret, 2);

        // ready held off 3 cycles, response 4 cycles late
        set_prog(32'h0070_0113, ILLEGAL);
        fix_rdy = 3; fix_dly = 4;
        apply_reset(); run_obs(60);
        chk("t2_req_cycles", o_req, 8);
        chk("t2_inst_cycle", o_inst1, 10);
        chk("t2_wen_cycle", o_wen1, 12);
        chk("t2_halt_cycle", o_halt, 23);
        chk("t2_cause", halt_cause, 2);
        chk("t2_retired", retired, 1);

        // addi x0,x0,1: no write to x0
        set_prog(32'h0010_0013, EBREAK_W);
        fix_rdy = 0; fix_dly = 0;
        apply_reset(); run_obs(50);
        chk("t3_ren", o_ren, 1);
        chk("t3_exu", o_exu, 1);
        chk("t3_wen", o_wen, 0);
        chk("t3_pc", pc, RESET_PC + 4);
        chk("t3_retired", retired, 2);

        // unsupported instruction
        set_prog(ILLEGAL, EBREAK_W);
        apply_reset(); run_obs(50);
        chk("t4_halt_cycle", o_halt, 4);
        chk("t4_cause", halt_cause, 2);
        chk("t4_retired", retired, 0);
        chk("t4_wen", o_wen, 0);
        chk("t4_pc", pc, RESET_PC);

        // fetch timeout, then a response on the last allowed cycle
        set_prog(EBREAK_W, EBREAK_W);
        fix_dly = 1000;
        apply_reset(); run_obs(400);
        chk("t5_timeout_cycle", o_halt, 2 + TIMEOUT);
        chk("t5_cause", halt_cause, 3);
        chk("t5_retired", retired, 0);
        fix_dly = TIMEOUT - 1;
        apply_reset(); run_obs(400);
        chk("t5b_halt_cycle", o_halt, 3 + TIMEOUT);
        chk("t5b_cause", halt_cause, 1);
        chk("t5b_inst", inst, EBREAK_W);

        // reset while executing
        set_prog(32'h0050_0093, EBREAK_W);
        fix_dly = 0;
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (exu_en) break;
        end
        chk("t6_exec_seen", exu_en, 1);
        rst = 1;
        @(posedge clk); @(negedge clk);
        chk("t6_req_valid", ifu_req_valid, 1);
        chk("t6_pc", pc, RESET_PC);
        chk("t6_retired", retired, 0);
        chk("t6_wen", rf_wen, 0);
        @(posedge clk); #1 rst = 0;
        run_obs(50);
        chk("t6_retired_after", retired, 2);

        // random programs, latencies, stray responses and occasional mid-run resets
        for (int r = 0; r < 30; r++) begin
            int len;
            for (int i = 0; i < 64; i++) prog[i] = ILLEGAL;
            len = $urandom_range(1, 12);
            for (int k = 0; k < len; k++) begin
                rnd = $urandom; rnd[6:0] = 7'b0010011; rnd[14:12] = 3'b000;
                prog[k] = rnd;
            end
            if ($urandom_range(0, 4) == 0) begin
                rnd = $urandom; rnd[6:0] = 7'b0110011;
                prog[$urandom_range(0, len - 1)] = rnd;
            end
            prog[len] = EBREAK_W;
            fix_rdy = -1;
            fix_dly = ($urandom_range(0, 9) == 0) ? int'($urandom_range(250, 260)) : -1;
            noise = 1;
            apply_reset();
            if (r % 4 == 3) begin
                repeat ($urandom_range(1, 30)) @(negedge clk);
                rst = 1;
                @(posedge clk); #1 rst = 0;
            end
            run_obs(3000);
        end

        noise = 0;
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs + 1);
        $fatal(1, "watchdog");
    end

endmodule
